// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition, target, mispredict/redirect and retire
// statistics, behind a 1- or 2-stage valid/ready pipeline with flush.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       cmp_op_i,
    input  logic [2:0]       cmp_funct_i,
    input  logic [XLEN-1:0]  cmp_num1_i,
    input  logic [XLEN-1:0]  cmp_num2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  offset_i,
    input  logic             jalr_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             taken_o,
    output logic [XLEN-1:0]  target_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);
    localparam logic [1:0] CMP_OP_NONE    = 2'b00;
    localparam logic [1:0] CMP_OP_COMPARE = 2'b01;
    localparam logic [1:0] CMP_OP_ALWAYS  = 2'b10;

    typedef struct packed {
        logic [1:0]      op;
        logic [2:0]      funct;
        logic            eq;
        logic            lt;
        logic            ltu;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_tgt;
    } s1_t;

    typedef struct packed {
        logic            taken;
        logic            mp;
        logic            is_br;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] rpc;
    } out_t;

    function automatic out_t resolve(input s1_t s);
        out_t r;
        logic c;
        r = '0;
        case (s.funct[2:1])
            2'b00:   c = s.eq;
            2'b10:   c = s.lt;
            2'b11:   c = s.ltu;
            default: c = 1'b0;
        endcase
        case (s.op)
            CMP_OP_COMPARE: r.taken = (s.funct[2:1] == 2'b01) ? 1'b0 : (c ^ s.funct[0]);
            CMP_OP_ALWAYS:  r.taken = 1'b1;
            default:        r.taken = 1'b0;
        endcase
        r.is_br = (s.op == CMP_OP_COMPARE) || (s.op == CMP_OP_ALWAYS);
        r.tgt   = s.tgt;
        r.mp    = (r.taken != s.pred_taken) || (r.taken && (s.tgt != s.pred_tgt));
        r.rpc   = r.taken ? s.tgt : (s.pc + XLEN'(4));
        return r;
    endfunction

    // JALR and PC-relative targets share one adder; bit 0 is cleared only for JALR.
    logic [XLEN-1:0] sum_c;
    s1_t             in_c;
    always_comb begin
        sum_c          = (jalr_i ? cmp_num1_i : pc_i) + offset_i;
        in_c.op        = cmp_op_i;
        in_c.funct     = cmp_funct_i;
        in_c.eq        = (cmp_num1_i == cmp_num2_i);
        in_c.lt        = ($signed(cmp_num1_i) < $signed(cmp_num2_i));
        in_c.ltu       = (cmp_num1_i < cmp_num2_i);
        in_c.tgt       = {sum_c[XLEN-1:1], sum_c[0] & ~jalr_i};
        in_c.pc        = pc_i;
        in_c.pred_taken = pred_taken_i;
        in_c.pred_tgt  = pred_target_i;
    end

    logic vo_q;
    out_t out_q;
    logic last_adv;
    assign last_adv = !vo_q || ready_i;

    generate
        if (PIPE_STAGES == 1) begin : g_p1
            assign ready_o = last_adv;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vo_q  <= 1'b0;
                    out_q <= '0;
                end else begin
                    if (flush_i)      vo_q <= 1'b0;
                    else if (ready_o) vo_q <= valid_i;
                    if (!flush_i && valid_i && ready_o) out_q <= resolve(in_c);
                end
            end
        end else begin : g_p2
            logic v1_q;
            s1_t  s1_q;
            assign ready_o = !v1_q || last_adv;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v1_q  <= 1'b0;
                    s1_q  <= '0;
                    vo_q  <= 1'b0;
                    out_q <= '0;
                end else begin
                    if (flush_i) begin
                        v1_q <= 1'b0;
                        vo_q <= 1'b0;
                    end else begin
                        if (ready_o)  v1_q <= valid_i;
                        if (last_adv) vo_q <= v1_q;
                    end
                    if (!flush_i && valid_i && ready_o) s1_q  <= in_c;
                    if (!flush_i && v1_q && last_adv)   out_q <= resolve(s1_q);
                end
            end
        end
    endgenerate

    logic             ret_c;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
    always_comb begin
        ret_c    = vo_q && ready_i && !flush_i;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (ret_c && out_q.is_br && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (ret_c && out_q.mp && (mp_cnt_q != '1))    mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign valid_o          = vo_q;
    assign taken_o          = out_q.taken;
    assign target_o         = out_q.tgt;
    assign mispredict_o     = out_q.mp;
    assign redirect_pc_o    = out_q.rpc;
    assign branch_cnt_o     = br_cnt_q;
    assign mispredict_cnt_o = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: three instances (1-stage, 2-stage, 1-stage with 4-bit counters)
// share the data inputs; each has its own valid/ready/flush.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  op;
    logic [2:0]  funct;
    logic [31:0] n1, n2, pc, off, ptgt;
    logic        jalr, pt;
    logic [2:0]  vld, rdy, fl, rdyo, vo, tk, mp;
    logic [31:0] tgt [3];
    logic [31:0] rpc [3];
    logic [31:0] bc0, mc0, bc1, mc1;
    logic [3:0]  bc2, mc2;

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(1), .CNT_W(32)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .valid_i(vld[0]), .ready_o(rdyo[0]),
        .cmp_op_i(op), .cmp_funct_i(funct), .cmp_num1_i(n1), .cmp_num2_i(n2), .pc_i(pc),
        .offset_i(off), .jalr_i(jalr), .pred_taken_i(pt), .pred_target_i(ptgt),
        .valid_o(vo[0]), .ready_i(rdy[0]), .taken_o(tk[0]), .target_o(tgt[0]),
        .mispredict_o(mp[0]), .redirect_pc_o(rpc[0]), .branch_cnt_o(bc0), .mispredict_cnt_o(mc0));

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(2), .CNT_W(32)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .valid_i(vld[1]), .ready_o(rdyo[1]),
        .cmp_op_i(op), .cmp_funct_i(funct), .cmp_num1_i(n1), .cmp_num2_i(n2), .pc_i(pc),
        .offset_i(off), .jalr_i(jalr), .pred_taken_i(pt), .pred_target_i(ptgt),
        .valid_o(vo[1]), .ready_i(rdy[1]), .taken_o(tk[1]), .target_o(tgt[1]),
        .mispredict_o(mp[1]), .redirect_pc_o(rpc[1]), .branch_cnt_o(bc1), .mispredict_cnt_o(mc1));

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(1), .CNT_W(4)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .valid_i(vld[2]), .ready_o(rdyo[2]),
        .cmp_op_i(op), .cmp_funct_i(funct), .cmp_num1_i(n1), .cmp_num2_i(n2), .pc_i(pc),
        .offset_i(off), .jalr_i(jalr), .pred_taken_i(pt), .pred_target_i(ptgt),
        .valid_o(vo[2]), .ready_i(rdy[2]), .taken_o(tk[2]), .target_o(tgt[2]),
        .mispredict_o(mp[2]), .redirect_pc_o(rpc[2]), .branch_cnt_o(bc2), .mispredict_cnt_o(mc2));

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f;
        logic [31:0] n1, n2, pc, off;
        logic        jalr, pt;
        logic [31:0] ptgt;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rpc;
    } vec_t;

    vec_t tv [12];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        op = v.op; funct = v.f; n1 = v.n1; n2 = v.n2; pc = v.pc; off = v.off;
        jalr = v.jalr; pt = v.pt; ptgt = v.ptgt;
    endtask

    task automatic chk_out(input string nm, input int u, input vec_t v);
        chk({nm, "_valid"}, 64'(vo[u]), 64'(1));
        chk({nm, "_taken"}, 64'(tk[u]), 64'(v.tk));
        chk({nm, "_target"}, 64'(tgt[u]), 64'(v.tgt));
        chk({nm, "_mispred"}, 64'(mp[u]), 64'(v.mp));
        chk({nm, "_redirect"}, 64'(rpc[u]), 64'(v.rpc));
    endtask

    function automatic int is_br(input logic [1:0] o);
        return (o == 2'd1 || o == 2'd2) ? 1 : 0;
    endfunction

    initial begin
        //         op    f       n1            n2            pc            off           jalr  pt    ptgt          tk    tgt           mp    rpc
        tv[0]  = '{2'd1, 3'b000, 32'h1234,     32'h1234,     32'h100,      32'h20,       1'b0, 1'b0, 32'h0,        1'b1, 32'h120,      1'b1, 32'h120};
        tv[1]  = '{2'd1, 3'b100, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b0, 1'b1, 32'h240,      1'b1, 32'h240,      1'b0, 32'h240};
        tv[2]  = '{2'd1, 3'b110, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h8,        1'b0, 1'b0, 32'h0,        1'b0, 32'h308,      1'b0, 32'h304};
        tv[3]  = '{2'd1, 3'b011, 32'h5,        32'h5,        32'h400,      32'h10,       1'b0, 1'b0, 32'h0,        1'b0, 32'h410,      1'b0, 32'h404};
        tv[4]  = '{2'd2, 3'b000, 32'h1001,     32'h0,        32'h500,      32'h10,       1'b1, 1'b1, 32'h1010,     1'b1, 32'h1010,     1'b0, 32'h1010};
        tv[5]  = '{2'd2, 3'b000, 32'h1001,     32'h0,        32'h500,      32'h10,       1'b1, 1'b1, 32'h1014,     1'b1, 32'h1010,     1'b1, 32'h1010};
        tv[6]  = '{2'd0, 3'b000, 32'h0,        32'h0,        32'h600,      32'h20,       1'b0, 1'b1, 32'h620,      1'b0, 32'h620,      1'b1, 32'h604};
        tv[7]  = '{2'd1, 3'b001, 32'h1,        32'h2,        32'h700,      32'hFFFFFFF0, 1'b0, 1'b1, 32'h6F0,      1'b1, 32'h6F0,      1'b0, 32'h6F0};
        tv[8]  = '{2'd1, 3'b101, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h20,       1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h10};
        tv[9]  = '{2'd1, 3'b111, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8,        1'b0, 1'b1, 32'h4,        1'b0, 32'h4,        1'b1, 32'h0};
        tv[10] = '{2'd3, 3'b000, 32'h7,        32'h7,        32'h800,      32'h4,        1'b0, 1'b0, 32'h0,        1'b0, 32'h804,      1'b0, 32'h804};
        tv[11] = '{2'd1, 3'b010, 32'h9,        32'h9,        32'h900,      32'h100,      1'b0, 1'b0, 32'h0,        1'b0, 32'hA00,      1'b0, 32'h904};

        rst = 1'b1; vld = '0; rdy = '0; fl = '0;
        apply(tv[0]);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            chk("rst_valid", 64'(vo[u]), 64'(0));
            chk("rst_ready", 64'(rdyo[u]), 64'(1));
            chk("rst_taken", 64'(tk[u]), 64'(0));
            chk("rst_target", 64'(tgt[u]), 64'(0));
            chk("rst_redirect", 64'(rpc[u]), 64'(0));
        end
        chk("rst_cnt", 64'({bc0, mc0}), 64'(0));

        // Table vectors through the 1-stage unit, one entry at a time.
        rdy[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply(tv[i]); vld[0] = 1'b1;
            @(posedge clk); #1 vld[0] = 1'b0;
            chk_out($sformatf("vec%0d", i), 0, tv[i]);
            exp_br += is_br(tv[i].op);
            exp_mp += int'(tv[i].mp);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_brcnt", i), 64'(bc0), 64'(exp_br));
            chk($sformatf("vec%0d_mpcnt", i), 64'(mc0), 64'(exp_mp));
            chk($sformatf("vec%0d_drain", i), 64'(vo[0]), 64'(0));
        end

        // Flush with an entry in flight and a new input offered.
        apply(tv[1]); vld[0] = 1'b1;
        @(posedge clk); #1;
        chk("fl_inflight", 64'(vo[0]), 64'(1));
        apply(tv[2]); fl[0] = 1'b1;
        @(posedge clk); #1 fl[0] = 1'b0;
        chk("fl_valid", 64'(vo[0]), 64'(0));
        chk("fl_ready", 64'(rdyo[0]), 64'(1));
        chk("fl_brcnt", 64'(bc0), 64'(exp_br));
        chk("fl_mpcnt", 64'(mc0), 64'(exp_mp));
        apply(tv[5]);
        @(posedge clk); #1 vld[0] = 1'b0;
        chk_out("fl_next", 0, tv[5]);
        @(posedge clk); #1;
        chk("fl_next_brcnt", 64'(bc0), 64'(exp_br + 1));
        chk("fl_next_mpcnt", 64'(mc0), 64'(exp_mp + 1));
        chk("fl_next_drain", 64'(vo[0]), 64'(0));

        // 2-stage: 4 back-to-back entries, ready_i low in cycles 3..5.
        begin
            int idx = 0, got = 0, ebr = 0, emp = 0;
            logic bp_seen = 1'b0, stall_prev = 1'b0, acc;
            logic [65:0] saved = '0;
            for (int c = 0; c < 20; c++) begin
                if (idx < 4) begin apply(tv[idx]); vld[1] = 1'b1; end
                else vld[1] = 1'b0;
                rdy[1] = !(c >= 3 && c <= 5);
                @(negedge clk);
                if (vld[1] && !rdyo[1]) bp_seen = 1'b1;
                if (stall_prev)
                    chk($sformatf("p2_stable_c%0d", c), 64'({vo[1], tk[1], mp[1], tgt[1][30:0], rpc[1][30:0]}),
                        64'(saved));
                stall_prev = vo[1] && !rdy[1];
                saved = {vo[1], tk[1], mp[1], tgt[1][30:0], rpc[1][30:0]};
                if (vo[1] && rdy[1]) begin
                    if (got < 4) chk_out($sformatf("p2_e%0d", got), 1, tv[got]);
                    else begin
                        n_chk++; n_fail++;
                        $display("FAIL p2_extra: got retire #%0d expected only 4", got + 1);
                    end
                    got++;
                end
                acc = vld[1] && rdyo[1];
                @(posedge clk); #1;
                if (acc) idx++;
            end
            vld[1] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ebr += is_br(tv[i].op);
                emp += int'(tv[i].mp);
            end
            chk("p2_retired", 64'(got), 64'(4));
            chk("p2_backpressure", 64'(bp_seen), 64'(1));
            chk("p2_brcnt", 64'(bc1), 64'(ebr));
            chk("p2_mpcnt", 64'(mc1), 64'(emp));
        end

        // 4-bit counters saturate after 20 mispredicting branches.
        apply(tv[0]); rdy[2] = 1'b1; vld[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("sat_mid_brcnt", 64'(bc2), 64'(9));
        repeat (10) @(posedge clk);
        #1 vld[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sat_brcnt", 64'(bc2), 64'(4'hF));
        chk("sat_mpcnt", 64'(mc2), 64'(4'hF));

        // Reset with an entry in flight.
        vld[2] = 1'b1;
        @(posedge clk); #1 vld[2] = 1'b0; rst = 1'b1;
        chk("rst2_inflight", 64'(vo[2]), 64'(1));
        @(posedge clk); #1 rst = 1'b0;
        chk("rst2_valid", 64'(vo[2]), 64'(0));
        chk("rst2_cnt", 64'({bc2, mc2}), 64'(0));
        chk("rst2_cnt_u1", 64'({bc0, mc0}), 64'(0));
        chk("rst2_ready", 64'(rdyo[2]), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
